// File: rtl/wr_ptr_full_ctrl.sv
// wr_ptr_full_ctrl: write-side pointer, full/almost-full and sticky overflow for an async FIFO.
// Defining WR_PTR_FULL_CTRL_LEVEL_EN adds the registered wr_level occupancy output.
module wr_ptr_full_ctrl #(
  parameter int ADDRW    = 5,
  parameter int AFULL_TH = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [ADDRW:0]   r2wsync_rptr,
  input  logic             ovf_clr,
  output logic             wen,
  output logic [ADDRW-1:0] waddr,
  output logic [ADDRW:0]   wptr,
  output logic             full,
  output logic             almost_full,
  output logic             overflow
`ifdef WR_PTR_FULL_CTRL_LEVEL_EN
  ,
  output logic [ADDRW:0]   wr_level
`endif
);
  localparam int DEPTH = 1 << ADDRW;
  localparam logic [ADDRW:0] AF_LVL = (ADDRW+1)'(DEPTH - AFULL_TH);
  logic [ADDRW:0] wbin_q, wbin_d, wptr_q, wptr_d, rbin, level_d;
  logic full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRW; i++) rbin[i] = ^(r2wsync_rptr >> i);
    wen     = winc & ~full_q & ~wrst;
    wbin_d  = wbin_q + (ADDRW+1)'(wen);
    wptr_d  = wbin_d ^ (wbin_d >> 1);
    // full when the write pointer has lapped the read pointer by exactly one turn
    full_d  = wptr_d == {~r2wsync_rptr[ADDRW:ADDRW-1], r2wsync_rptr[ADDRW-2:0]};
    level_d = wbin_d - rbin;
    afull_d = level_d >= AF_LVL;
    ovf_d   = (winc & full_q) | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef WR_PTR_FULL_CTRL_LEVEL_EN
  logic [ADDRW:0] level_q;
  always_ff @(posedge wclk) level_q <= wrst ? '0 : level_d;
  assign wr_level = level_q;
`endif
  assign waddr       = wbin_q[ADDRW-1:0];
  assign wptr        = wptr_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// tb_wr_ptr_full_ctrl: directed rows with hand-computed expectations, queued by the driver
// and checked by an independent monitor on the falling edge (ADDRW=3, AFULL_TH=2).
module tb_wr_ptr_full_ctrl;
  logic       wclk = 1'b0;
  logic       wrst, winc, ovf_clr;
  logic [3:0] r2wsync_rptr;
  logic       wen, full, almost_full, overflow;
  logic [2:0] waddr;
  logic [3:0] wptr;
`ifdef WR_PTR_FULL_CTRL_LEVEL_EN
  logic [3:0] wr_level;
`endif
  typedef struct packed {
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full, af, ovf;
    logic [3:0] lvl;
  } exp_t;
  exp_t q[$];
  int   row_q[$];
  int   n_chk = 0, n_fail = 0, row = 0;
  wr_ptr_full_ctrl #(.ADDRW(3), .AFULL_TH(2)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .r2wsync_rptr(r2wsync_rptr), .ovf_clr(ovf_clr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .full(full), .almost_full(almost_full),
    .overflow(overflow)
`ifdef WR_PTR_FULL_CTRL_LEVEL_EN
    , .wr_level(wr_level)
`endif
  );
  always #5 wclk = ~wclk;
  task automatic chk(input string nm, input int r, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, r, act, exp);
    end
  endtask
  always @(negedge wclk) begin
    if (q.size() > 0) begin
      exp_t e;
      int   r;
      e = q.pop_front();
      r = row_q.pop_front();
      chk("wen", r, int'(wen), int'(e.wen));
      chk("waddr", r, int'(waddr), int'(e.waddr));
      chk("wptr", r, int'(wptr), int'(e.wptr));
      chk("full", r, int'(full), int'(e.full));
      chk("almost_full", r, int'(almost_full), int'(e.af));
      chk("overflow", r, int'(overflow), int'(e.ovf));
`ifdef WR_PTR_FULL_CTRL_LEVEL_EN
      chk("wr_level", r, int'(wr_level), int'(e.lvl));
`endif
    end
  end
  task automatic step(input logic r, input logic w, input logic [3:0] rp, input logic c,
                      input logic e_wen, input logic [2:0] e_wa, input logic [3:0] e_wp,
                      input logic e_f, input logic e_af, input logic e_ov, input logic [3:0] e_l);
    wrst = r; winc = w; r2wsync_rptr = rp; ovf_clr = c;
    q.push_back('{wen: e_wen, waddr: e_wa, wptr: e_wp, full: e_f, af: e_af, ovf: e_ov, lvl: e_l});
    row_q.push_back(row);
    row++;
    @(posedge wclk);
    #1;
  endtask
  initial begin
    wrst = 1'b1; winc = 1'b0; ovf_clr = 1'b0; r2wsync_rptr = 4'd0;
    @(posedge wclk);
    #1;
    // reset held with winc high: wen forced low
    step(1, 1, 4'd0, 0,   0, 3'd0, 4'd0,  0, 0, 0, 4'd0);
    // fill against rptr=0
    step(0, 1, 4'd0, 0,   1, 3'd0, 4'd0,  0, 0, 0, 4'd0);
    step(0, 1, 4'd0, 0,   1, 3'd1, 4'd1,  0, 0, 0, 4'd1);
    step(0, 1, 4'd0, 0,   1, 3'd2, 4'd3,  0, 0, 0, 4'd2);
    step(0, 1, 4'd0, 0,   1, 3'd3, 4'd2,  0, 0, 0, 4'd3);
    step(0, 1, 4'd0, 0,   1, 3'd4, 4'd6,  0, 0, 0, 4'd4);
    step(0, 1, 4'd0, 0,   1, 3'd5, 4'd7,  0, 0, 0, 4'd5);
    step(0, 1, 4'd0, 0,   1, 3'd6, 4'd5,  0, 1, 0, 4'd6);
    step(0, 1, 4'd0, 0,   1, 3'd7, 4'd4,  0, 1, 0, 4'd7);
    // full: writes ignored, overflow sets
    step(0, 1, 4'd0, 0,   0, 3'd0, 4'd12, 1, 1, 0, 4'd8);
    step(0, 1, 4'd0, 0,   0, 3'd0, 4'd12, 1, 1, 1, 4'd8);
    step(0, 0, 4'd0, 1,   0, 3'd0, 4'd12, 1, 1, 1, 4'd8);
    // overflow event and clear together: set wins
    step(0, 1, 4'd0, 1,   0, 3'd0, 4'd12, 1, 1, 0, 4'd8);
    step(0, 0, 4'd0, 0,   0, 3'd0, 4'd12, 1, 1, 1, 4'd8);
    step(0, 0, 4'd0, 1,   0, 3'd0, 4'd12, 1, 1, 1, 4'd8);
    // read pointer advances; full drops one cycle later
    step(0, 0, 4'd1, 0,   0, 3'd0, 4'd12, 1, 1, 0, 4'd8);
    // continuous write while rptr steps through Gray 2..15,0,1 (wbin wraps 15->0)
    step(0, 1, 4'd3,  0,  1, 3'd0, 4'd12, 0, 1, 0, 4'd7);
    step(0, 1, 4'd2,  0,  1, 3'd1, 4'd13, 0, 1, 0, 4'd7);
    step(0, 1, 4'd6,  0,  1, 3'd2, 4'd15, 0, 1, 0, 4'd7);
    step(0, 1, 4'd7,  0,  1, 3'd3, 4'd14, 0, 1, 0, 4'd7);
    step(0, 1, 4'd5,  0,  1, 3'd4, 4'd10, 0, 1, 0, 4'd7);
    step(0, 1, 4'd4,  0,  1, 3'd5, 4'd11, 0, 1, 0, 4'd7);
    step(0, 1, 4'd12, 0,  1, 3'd6, 4'd9,  0, 1, 0, 4'd7);
    step(0, 1, 4'd13, 0,  1, 3'd7, 4'd8,  0, 1, 0, 4'd7);
    step(0, 1, 4'd15, 0,  1, 3'd0, 4'd0,  0, 1, 0, 4'd7);
    step(0, 1, 4'd14, 0,  1, 3'd1, 4'd1,  0, 1, 0, 4'd7);
    step(0, 1, 4'd10, 0,  1, 3'd2, 4'd3,  0, 1, 0, 4'd7);
    step(0, 1, 4'd11, 0,  1, 3'd3, 4'd2,  0, 1, 0, 4'd7);
    step(0, 1, 4'd9,  0,  1, 3'd4, 4'd6,  0, 1, 0, 4'd7);
    step(0, 1, 4'd8,  0,  1, 3'd5, 4'd7,  0, 1, 0, 4'd7);
    step(0, 1, 4'd0,  0,  1, 3'd6, 4'd5,  0, 1, 0, 4'd7);
    step(0, 1, 4'd1,  0,  1, 3'd7, 4'd4,  0, 1, 0, 4'd7);
    // rptr held: last slot fills, then full
    step(0, 1, 4'd1,  0,  1, 3'd0, 4'd12, 0, 1, 0, 4'd7);
    step(0, 1, 4'd1,  0,  0, 3'd1, 4'd13, 1, 1, 0, 4'd8);
    // reset from full with overflow set
    step(1, 1, 4'd1,  0,  0, 3'd1, 4'd13, 1, 1, 1, 4'd8);
    // refill to level 5 then reset mid-fill
    step(0, 1, 4'd0,  0,  1, 3'd0, 4'd0,  0, 0, 0, 4'd0);
    step(0, 1, 4'd0,  0,  1, 3'd1, 4'd1,  0, 0, 0, 4'd1);
    step(0, 1, 4'd0,  0,  1, 3'd2, 4'd3,  0, 0, 0, 4'd2);
    step(0, 1, 4'd0,  0,  1, 3'd3, 4'd2,  0, 0, 0, 4'd3);
    step(0, 1, 4'd0,  0,  1, 3'd4, 4'd6,  0, 0, 0, 4'd4);
    step(1, 1, 4'd0,  0,  0, 3'd5, 4'd7,  0, 0, 0, 4'd5);
    step(0, 0, 4'd0,  0,  0, 3'd0, 4'd0,  0, 0, 0, 4'd0);
    repeat (4) if (q.size() > 0) @(negedge wclk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
